// File: rtl/wb_queue_if.sv
// Write-back request channel between a producer and the write-back queue.
// The producer holds a request until in_ready is high.
interface wb_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;

  modport master (output in_valid, in_reg, in_data, input in_ready);
  modport slave  (input in_valid, in_reg, in_data, output in_ready);
endinterface

// File: rtl/wb_queue.sv
// In-order write-back queue feeding the register-file write port, with
// youngest-match forwarding lookups for two source operands.

// One forwarding lookup port: scans pending entries oldest to youngest so the
// youngest match is the one left standing.
module wb_queue_lookup #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic [DEPTH-1:0][4:0]  ent_reg,
  input  logic [DEPTH-1:0][31:0] ent_data,
  input  logic [AW-1:0]          head,
  input  logic [AW:0]            count,
  input  logic [4:0]             addr,
  output logic                   hit,
  output logic [31:0]            data
);
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((AW+1)'(i) < count && addr != 5'd0 &&
          ent_reg[head + AW'(i)] == addr) begin
        hit  = 1'b1;
        data = ent_data[head + AW'(i)];
      end
    end
  end
endmodule

module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  wb_queue_if.slave                req,
  input  logic                     drain_hold,
  output logic                     RegWrite,
  output logic [4:0]               writereg,
  output logic [31:0]              writedate,
  input  logic [4:0]               rs,
  input  logic [4:0]               rt,
  output logic                     hit1,
  output logic                     hit2,
  output logic [31:0]              fwd1,
  output logic [31:0]              fwd2,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int NUM_LANES = 2;

  logic [DEPTH-1:0][4:0]  ent_reg;
  logic [DEPTH-1:0][31:0] ent_data;
  logic [AW-1:0]          head, tail;
  logic                   accept, push, drain;

  // Ready looks only at registered occupancy, never at this cycle's drain.
  assign req.in_ready = count < (AW+1)'(DEPTH);
  assign accept       = req.in_valid && req.in_ready;
  assign push         = accept && req.in_reg != 5'd0;
  assign RegWrite     = count != '0 && !drain_hold;
  assign drain        = RegWrite;

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)  tail <= tail + AW'(1);
      if (drain) head <= head + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(drain);
    end
  end

  // Payload storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      ent_reg[tail]  <= req.in_reg;
      ent_data[tail] <= req.in_data;
    end
  end

  assign writereg  = (count != '0) ? ent_reg[head]  : 5'd0;
  assign writedate = (count != '0) ? ent_data[head] : 32'd0;

  logic [NUM_LANES-1:0][4:0]  lk_addr;
  logic [NUM_LANES-1:0]       lk_hit;
  logic [NUM_LANES-1:0][31:0] lk_data;

  assign lk_addr = {rt, rs};

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      wb_queue_lookup #(.DEPTH(DEPTH), .AW(AW)) u_lookup (
        .ent_reg  (ent_reg),
        .ent_data (ent_data),
        .head     (head),
        .count    (count),
        .addr     (lk_addr[g]),
        .hit      (lk_hit[g]),
        .data     (lk_data[g])
      );
    end
  endgenerate

  assign hit1 = lk_hit[0];
  assign hit2 = lk_hit[1];
  assign fwd1 = lk_data[0];
  assign fwd2 = lk_data[1];
endmodule

// File: tb/tb_wb_queue.sv
// Bench for wb_queue: directed vector table, hand sequences for fill, wrap
// and reset, then random traffic against a queue-based reference model.
module tb_wb_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, drain_hold;
  logic [4:0]  rs, rt, writereg;
  logic        RegWrite, hit1, hit2;
  logic [31:0] writedate, fwd1, fwd2;
  logic [$clog2(DEPTH):0] count;

  wb_queue_if bus();

  wb_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .req(bus.slave), .drain_hold(drain_hold),
    .RegWrite(RegWrite), .writereg(writereg), .writedate(writedate),
    .rs(rs), .rt(rt), .hit1(hit1), .hit2(hit2), .fwd1(fwd1), .fwd2(fwd2),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {logic [4:0] r; logic [31:0] d;} ent_t;
  ent_t mq[$];

  typedef struct {
    logic v; logic [4:0] r; logic [31:0] d; logic hold; logic [4:0] rs, rt;
    int cnt; logic rdy, rw; logic [4:0] wr; logic [31:0] wd;
    logic h1; logic [31:0] f1; logic h2; logic [31:0] f2;
  } vec_t;
  vec_t tv[11];

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic v, input logic [4:0] r,
                       input logic [31:0] d, input logic hold,
                       input logic [4:0] a, input logic [4:0] b);
    reset = rst; bus.in_valid = v; bus.in_reg = r; bus.in_data = d;
    drain_hold = hold; rs = a; rt = b;
    #1;
  endtask

  // Reference: pop the head if draining, append accepted non-zero requests.
  task automatic tick();
    bit drn, acc;
    @(posedge clk);
    if (reset) mq.delete();
    else begin
      drn = mq.size() != 0 && !drain_hold;
      acc = bus.in_valid && mq.size() < DEPTH;
      if (drn) void'(mq.pop_front());
      if (acc && bus.in_reg != 5'd0) mq.push_back('{bus.in_reg, bus.in_data});
    end
    @(negedge clk);
  endtask

  task automatic model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0; d = '0;
    if (a != 5'd0)
      foreach (mq[i]) if (mq[i].r == a) begin h = 1'b1; d = mq[i].d; end
  endtask

  task automatic check_model();
    logic h; logic [31:0] d;
    int n;
    n = mq.size();
    chk("rnd_count", 32'(count), 32'(n));
    chk("rnd_ready", 32'(bus.in_ready), 32'(n < DEPTH));
    chk("rnd_regwrite", 32'(RegWrite), 32'(n != 0 && !drain_hold));
    chk("rnd_writereg", 32'(writereg), n != 0 ? 32'(mq[0].r) : 32'd0);
    chk("rnd_writedate", writedate, n != 0 ? mq[0].d : 32'd0);
    model_lookup(rs, h, d);
    chk("rnd_hit1", 32'(hit1), 32'(h));
    chk("rnd_fwd1", fwd1, d);
    model_lookup(rt, h, d);
    chk("rnd_hit2", 32'(hit2), 32'(h));
    chk("rnd_fwd2", fwd2, d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    tv[0]  = '{1, 5, 'h1234, 0, 5, 0, 0, 1, 0, 0, 0,       0, 0,       0, 0};
    tv[1]  = '{0, 0, 0,      0, 5, 5, 1, 1, 1, 5, 'h1234,  1, 'h1234,  1, 'h1234};
    tv[2]  = '{0, 0, 0,      0, 5, 0, 0, 1, 0, 0, 0,       0, 0,       0, 0};
    tv[3]  = '{1, 0, 'hFFFF, 0, 0, 0, 0, 1, 0, 0, 0,       0, 0,       0, 0};
    tv[4]  = '{0, 0, 0,      0, 0, 0, 0, 1, 0, 0, 0,       0, 0,       0, 0};
    tv[5]  = '{1, 7, 'hA,    1, 7, 0, 0, 1, 0, 0, 0,       0, 0,       0, 0};
    tv[6]  = '{1, 7, 'hB,    1, 7, 0, 1, 1, 0, 7, 'hA,     1, 'hA,     0, 0};
    tv[7]  = '{0, 0, 0,      1, 7, 0, 2, 1, 0, 7, 'hA,     1, 'hB,     0, 0};
    tv[8]  = '{0, 0, 0,      0, 7, 7, 2, 1, 1, 7, 'hA,     1, 'hB,     1, 'hB};
    tv[9]  = '{0, 0, 0,      0, 7, 0, 1, 1, 1, 7, 'hB,     1, 'hB,     0, 0};
    tv[10] = '{0, 0, 0,      0, 7, 0, 0, 1, 0, 0, 0,       0, 0,       0, 0};

    drive(1, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    drive(0, 0, 0, 0, 0, 5, 5);
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_regwrite", 32'(RegWrite), 0);
    chk("rst_writereg", 32'(writereg), 0);
    chk("rst_writedate", writedate, 0);
    chk("rst_hit1", 32'(hit1), 0);
    chk("rst_hit2", 32'(hit2), 0);

    foreach (tv[i]) begin
      drive(0, tv[i].v, tv[i].r, tv[i].d, tv[i].hold, tv[i].rs, tv[i].rt);
      chk($sformatf("v%0d_count", i), 32'(count), 32'(tv[i].cnt));
      chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(tv[i].rdy));
      chk($sformatf("v%0d_regwrite", i), 32'(RegWrite), 32'(tv[i].rw));
      chk($sformatf("v%0d_writereg", i), 32'(writereg), 32'(tv[i].wr));
      chk($sformatf("v%0d_writedate", i), writedate, tv[i].wd);
      chk($sformatf("v%0d_hit1", i), 32'(hit1), 32'(tv[i].h1));
      chk($sformatf("v%0d_fwd1", i), fwd1, tv[i].f1);
      chk($sformatf("v%0d_hit2", i), 32'(hit2), 32'(tv[i].h2));
      chk($sformatf("v%0d_fwd2", i), fwd2, tv[i].f2);
      tick();
    end

    // Fill under hold, reject a fifth push, then drain in order.
    for (int k = 1; k <= 4; k++) begin
      drive(0, 1, 5'(k), 32'h100 + 32'(k), 1, 0, 0);
      tick();
    end
    drive(0, 1, 9, 32'h999, 1, 9, 0);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(bus.in_ready), 0);
    tick();
    drive(0, 0, 0, 0, 1, 9, 0);
    chk("full_no_accept", 32'(count), 4);
    chk("full_no_hit", 32'(hit1), 0);
    for (int k = 1; k <= 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("drain_regwrite", 32'(RegWrite), 1);
      chk("drain_writereg", 32'(writereg), 32'(k));
      chk("drain_writedate", writedate, 32'h100 + 32'(k));
      chk("drain_count", 32'(count), 32'(5 - k));
      tick();
    end
    chk("drain_empty", 32'(count), 0);

    // Push and drain together at count=2 across pointer wrap.
    drive(0, 1, 1, 0, 1, 0, 0); tick();
    drive(0, 1, 2, 1, 1, 0, 0); tick();
    for (int j = 0; j < 10; j++) begin
      drive(0, 1, 5'((j + 2) % 31 + 1), 32'(j + 2), 0, 0, 0);
      chk("wrap_count", 32'(count), 2);
      chk("wrap_ready", 32'(bus.in_ready), 1);
      chk("wrap_writedate", writedate, 32'(j));
      tick();
    end
    for (int j = 10; j < 12; j++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("wrap_tail_writedate", writedate, 32'(j));
      tick();
    end
    chk("wrap_empty", 32'(count), 0);

    // Reset with pending entries and a simultaneous offered request.
    drive(0, 1, 3, 33, 1, 0, 0); tick();
    drive(0, 1, 4, 44, 1, 0, 0); tick();
    drive(0, 1, 5, 55, 1, 0, 0); tick();
    drive(1, 1, 6, 66, 0, 3, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("midrst_count", 32'(count), 0);
    chk("midrst_regwrite", 32'(RegWrite), 0);
    for (int r = 0; r < 32; r++) begin
      drive(0, 0, 0, 0, 0, 5'(r), 5'(r));
      chk($sformatf("midrst_hit1_r%0d", r), 32'(hit1), 0);
      tick();
    end

    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
            5'($urandom_range(0, 7)), $urandom, $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      check_model();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_queue.md
WB_QUEUE -- requirements
Module: wb_queue

Interface
REQ-001 Parameter DEPTH, default 4, sets the number of pending write-back entries; legal values are 2, 4 and 8.
REQ-002 Port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 Port reset, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-004 Port in_valid, input, 1, a write-back request is offered this cycle.
REQ-005 Port in_ready, output, 1, the queue accepts the offered request this cycle.
REQ-006 Port in_reg, input, 5, destination register number of the offered request.
REQ-007 Port in_data, input, 32, write data of the offered request.
REQ-008 Port drain_hold, input, 1, when high, draining to the register file is suppressed this cycle.
REQ-009 Port RegWrite, output, 1, register-file write enable.
REQ-010 Port writereg, output, 5, register-file write address.
REQ-011 Port writedate, output, 32, register-file write data.
REQ-012 Port rs, input, 5, forwarding lookup address for the first operand.
REQ-013 Port rt, input, 5, forwarding lookup address for the second operand.
REQ-014 Port hit1, output, 1, a pending entry matches rs.
REQ-015 Port hit2, output, 1, a pending entry matches rt.
REQ-016 Port fwd1, output, 32, data of the youngest pending entry matching rs.
REQ-017 Port fwd2, output, 32, data of the youngest pending entry matching rt.
REQ-018 Port count, output, log2(DEPTH)+1, number of pending entries.

Function
REQ-019 The block SHALL be an in-order FIFO of {reg, data} entries that drives the register-file write port (the writer side of that port).
REQ-020 in_ready SHALL equal (count < DEPTH) and SHALL be registered-state-derived only; it does not depend on this cycle's drain.
REQ-021 An accept occurs when in_valid and in_ready are both high; the entry is written at the tail on that rising edge.
REQ-022 A request with in_reg == 0 SHALL be accepted when in_ready is high and then discarded; it occupies no entry and does not change count.
REQ-023 RegWrite SHALL equal (count != 0) && !drain_hold, combinationally.
REQ-024 writereg and writedate SHALL show the head entry whenever count != 0, and SHALL be 0 when the queue is empty.
REQ-025 A drain occurs when RegWrite is high; the head entry is popped on that rising edge, so at most one entry drains per cycle. The register file commits the write on the falling edge inside the same cycle.
REQ-026 When an accept and a drain occur in the same cycle, count SHALL stay unchanged and both pointers SHALL advance.
REQ-027 Pointers SHALL wrap modulo DEPTH.
REQ-028 A lookup on rs or rt SHALL search all pending entries, including the head entry being drained this cycle; the youngest match wins.
REQ-029 A request offered in the same cycle as a lookup SHALL NOT be visible to that lookup.
REQ-030 Lookups on address 0 SHALL return hit 0 and data 0.
REQ-031 On a miss, fwdN SHALL be 0.
REQ-032 Lookup outputs SHALL be purely combinational from state and rs/rt, with zero-cycle latency.
REQ-033 A request offered while full SHALL NOT be accepted; the requester holds it until in_ready is high.

Reset
REQ-034 When reset is high at a rising edge, count and both pointers SHALL clear to 0, all pending entries SHALL be dropped, and any simultaneous accept or drain SHALL be ignored.
REQ-035 Entry storage SHALL NOT require reset.
REQ-036 While count is 0, RegWrite, writereg, writedate, hit1, hit2, fwd1 and fwd2 SHALL all be 0. in_ready SHALL be 1 after reset.

Verification
REQ-037 Single write: push (r5, 0x1234) -> the next cycle shows RegWrite=1, writereg=5, writedate=0x1234; the cycle after, count=0 and RegWrite=0.
REQ-038 Fill with drain_hold=1: push 4 entries (r1..r4) -> count=4, in_ready=0, a fifth push is not accepted; release hold -> r1..r4 drain in order over 4 cycles.
REQ-039 Forwarding priority with drain_hold=1: push (r7, 0xA) then (r7, 0xB); set rs=7, rt=0 -> hit1=1, fwd1=0xB, hit2=0, fwd2=0.
REQ-040 Simultaneous accept and drain at count=4 is impossible because in_ready=0; at count=2, push and drain together -> count stays 2, and write order is preserved across pointer wrap over 10 pushes.
REQ-041 Zero register: push (r0, 0xFFFF) -> in_ready=1, count unchanged, RegWrite never shows writereg=0.
REQ-042 Reset mid-operation: with 3 pending entries, assert reset with in_valid=1 -> next cycle count=0, RegWrite=0, hit1=0 for all rs.
